// File: rtl/aes_pkg.sv
// Shared AES types, round constants and byte-level helpers.
// Used by aes_key_sched and aes_sub_word.
package aes_pkg;

  typedef logic [127:0] aes_128;
  typedef logic [31:0]  aes_word;

  // Round constants. RCON[r] is the constant used to produce the key of round r.
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Forward S-box, row 0 in the most significant bits so entry x sits at bit (255-x)*8.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte substitution; ~b equals 255-b, which locates the entry in the flat table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  // Rotate a word left by one byte: byte 0 moves to the last position.
  function automatic aes_word rot_word(input aes_word w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-boxes applied to a 32-bit word; purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word word_i,
  output aes_word word_o
);

  // Substitute each byte independently.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[i*8 +: 8] = sbox(word_i[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_sched.sv
// On-the-fly AES-128 key schedule: holds one round key and steps it per request.
// Define AES_KEY_REWIND_EN to add the prev_i port and the inverse (rewind) datapath.
module aes_key_sched
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load_i,
  input  logic       next_i,
`ifdef AES_KEY_REWIND_EN
  input  logic       prev_i,
`endif
  input  aes_128     key_i,
  output aes_128     rnd_key_o,
  output logic [3:0] rnd_o,
  output logic       valid_o,
  output logic       zero_rnd_o,
  output logic       final_rnd_o
);

  localparam logic [3:0] LAST_RND = 4'd10;

  aes_128     key_q, key_d;
  logic [3:0] rnd_q, rnd_d;
  logic       valid_q, valid_d;

  aes_word w0, w1, w2, w3;
  aes_word fwdSub, fwdTemp;
  aes_word n0, n1, n2, n3;
  logic [7:0] rconFwd;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Constant for the round being entered; zero at the last round, where stepping is blocked.
  assign rconFwd = (rnd_q < LAST_RND) ? RCON[rnd_q + 4'd1] : 8'h00;

  aes_sub_word uFwdSub (
    .word_i (rot_word(w3)),
    .word_o (fwdSub)
  );

  assign fwdTemp = fwdSub ^ {rconFwd, 24'h0};
  assign n0 = w0 ^ fwdTemp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

`ifdef AES_KEY_REWIND_EN
  aes_word p0, p1, p2, p3;
  aes_word invSub;
  logic [7:0] rconInv;

  // The current round's key was built with RCON[r]; round 0 has none and cannot rewind.
  assign rconInv = (rnd_q != 4'd0 && rnd_q <= LAST_RND) ? RCON[rnd_q] : 8'h00;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sub_word uInvSub (
    .word_i (rot_word(p3)),
    .word_o (invSub)
  );

  assign p0 = w0 ^ invSub ^ {rconInv, 24'h0};
`endif

  // Next-state selection: load wins, stepping only once a key is present.
  always_comb begin
    key_d   = key_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    if (load_i) begin
      key_d   = key_i;
      rnd_d   = 4'd0;
      valid_d = 1'b1;
    end else if (valid_q) begin
`ifdef AES_KEY_REWIND_EN
      if (next_i && !prev_i && rnd_q != LAST_RND) begin
        key_d = {n0, n1, n2, n3};
        rnd_d = rnd_q + 4'd1;
      end else if (prev_i && !next_i && rnd_q != 4'd0) begin
        key_d = {p0, p1, p2, p3};
        rnd_d = rnd_q - 4'd1;
      end
`else
      if (next_i && rnd_q != LAST_RND) begin
        key_d = {n0, n1, n2, n3};
        rnd_d = rnd_q + 4'd1;
      end
`endif
    end
  end

  // State registers: reset overrides the stall, stall freezes everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      rnd_q   <= 4'd0;
      valid_q <= 1'b0;
    end else if (en) begin
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  assign rnd_key_o   = key_q;
  assign rnd_o       = rnd_q;
  assign valid_o     = valid_q;
  assign zero_rnd_o  = valid_q && (rnd_q == 4'd0);
  assign final_rnd_o = valid_q && (rnd_q == LAST_RND);

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

On-the-fly AES-128 key schedule that produces round keys for `aes_enc`. It drives `key_i` and `rnd_key_i` of `aes_enc`, and its `zero_rnd_o`/`final_rnd_o` flags feed the matching control inputs. It holds one 128-bit round key and advances it one round per `next_i` request, so the full 11-key expansion is never stored.

## Interface
- No parameters; widths are fixed by `aes_pkg::aes_128`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global stall. When low, all state freezes and `load_i`/`next_i`/`prev_i` are ignored.
- `load_i` in 1: capture `key_i` as the round-0 key.
- `next_i` in 1: advance to round r+1.
- `prev_i` in 1: step back to round r−1. Present only with `AES_KEY_REWIND_EN`.
- `key_i` in `aes_128`: cipher key. Byte 0 is `[127:120]`; word w0 is `[127:96]`.
- `rnd_key_o` out `aes_128`: current round key (registered).
- `rnd_o` out 4: current round index, 0..10.
- `valid_o` out 1: a key has been loaded since reset.
- `zero_rnd_o` out 1: `valid_o && rnd_o==0`.
- `final_rnd_o` out 1: `valid_o && rnd_o==10`.

## Operation
- State registers: `key_q` (128 bits), `rnd_q` (4 bits), `valid_q`.
- Reset values: `rnd_key_o=0`, `rnd_o=0`, `valid_o=0`, and therefore `zero_rnd_o=0`, `final_rnd_o=0`.
- Priority when `en=1`: `load_i` > `next_i`/`prev_i`.
- `load_i`: `key_q←key_i`, `rnd_q←0`, `valid_q←1`. Any `next_i`/`prev_i` in the same cycle is dropped.
- Forward step (`next_i`, round r→r+1), with input words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {RCON[r+1], 24'h0}
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- `next_i` at `rnd_q==10`: ignored; state holds (saturates, no wrap).
- `next_i` or `prev_i` while `valid_q==0`: ignored.
- RCON is indexed by the round number: 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
- RotWord rotates bytes left by one, so byte 0 moves to the last position.
- `rst` takes effect regardless of `en` and discards any operation in progress, including mid-schedule.

## Timing
- Latency: a request sampled at edge n is visible on `rnd_key_o`/`rnd_o` immediately after edge n.
- Throughput: one round step per cycle, so back-to-back `next_i` walks rounds 0→10 in 10 cycles.
- All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
- `en` low for k cycles delays every transition by exactly k cycles.

## Configuration
- `AES_KEY_REWIND_EN` defined: adds port `prev_i` for decryption-order stepping.
  - Inverse step, from words w' back to w:
    - w3 = w3' ^ w2'
    - w2 = w2' ^ w1'
    - w1 = w1' ^ w0'
    - w0 = w0' ^ SubWord(RotWord(w3)) ^ {RCON[r], 24'h0}
  - `prev_i` at round 0 is ignored.
  - `next_i` and `prev_i` asserted together: both ignored, state holds.
- `AES_KEY_REWIND_EN` undefined: no `prev_i` port, forward stepping only, and the inverse datapath is absent.

## Structure
- `aes_pkg` holds:
  - the `aes_128` typedef (existing);
  - `aes_word` (32 bits);
  - the `RCON` constant array indexed 1..10;
  - functions `rot_word` and `sbox`, the forward S-box table or function shared with the datapath.
- One sub-module, `aes_sub_word`: 4 parallel S-boxes on a 32-bit word, purely combinational.
  - Forward step: one instance fed by w3.
  - Inverse step: a second instance fed by the reconstructed w3.

## Test plan
- FIPS-197 A.1 load: `key_i=2b7e151628aed2a6abf7158809cf4f3c`, assert `load_i`.
  - Next cycle: `rnd_key_o` equals `key_i`, `rnd_o=0`, `zero_rnd_o=1`, `valid_o=1`.
  - After one `next_i`: `rnd_key_o=a0fafe1788542cb123a339392a6c7605`.
  - After ten `next_i`: `rnd_key_o=d014f9a8c9ee2589e13f0cc8b6630ca6`, `final_rnd_o=1`.
- Zero-key check: `key_i=0`, `load_i` then `next_i` → `rnd_key_o=62636363626363636263636362636363`.
- Saturation and idle guard:
  - An extra `next_i` at round 10 leaves key and `rnd_o=10` unchanged.
  - `next_i` before any load leaves `valid_o=0` and `rnd_key_o=0`.
- Stall and priority:
  - Hold `en=0` for 3 cycles during `next_i` → no change.
  - `load_i` and `next_i` together mid-schedule → round 0 with the new key.
- Reset mid-schedule: assert `rst` at round 5 → all outputs 0 next cycle, `valid_o=0`.
- Rewind (with `AES_KEY_REWIND_EN` defined):
  - Ten `next_i` then ten `prev_i` → `rnd_key_o` returns to `2b7e1516…4f3c`, `rnd_o=0`.
  - `next_i` and `prev_i` together → state holds.
